mux_sel_arbiter: RTL and testbench



---
 rtl/mux_sel_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mux_sel_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: two-input round-robin arbiter that drives the select line of
// the downstream 2:1 mux and registers the chosen beat into a single-entry
// valid/ready output stage.
//
// Optional build macro: MUX_SEL_ARB_STATS_EN
//   When defined, per-input grant counters (a_grant_cnt, b_grant_cnt, CNT_W bits,
//   wrapping) and a synchronous clear input (stats_clr) are added.
//   When undefined, those ports and counters do not exist.
module mux_sel_arbiter #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [W-1:0]     a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [W-1:0]     b_data,
    output logic             b_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic             out_src,
`ifdef MUX_SEL_ARB_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] a_grant_cnt,
    output logic [CNT_W-1:0] b_grant_cnt,
`endif
    input  logic             out_ready
);

    // Output stage occupancy: EMPTY means no beat held, FULL means out_valid.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic           last_grant_r;
    logic [W-1:0]   out_data_r;
    logic           out_src_r;
    logic           sel_s;
    logic           accept_s;
    logic           xfer_a_s;
    logic           xfer_b_s;
    logic           xfer_s;

    // Round-robin decision: lone requester wins, contention alternates against
    // the last winner, and an idle cycle holds the select steady.
    function automatic logic grant_sel(input logic av, input logic bv, input logic last);
        logic g;
        case ({av, bv})
            2'b10:   g = 1'b0;
            2'b01:   g = 1'b1;
            2'b11:   g = ~last;
            default: g = last;
        endcase
        return g;
    endfunction

    // Grant, accept and handshake decode; no handshake is offered while in reset.
    always_comb begin
        sel_s    = grant_sel(a_valid, b_valid, last_grant_r);
        accept_s = (state_r == ST_EMPTY) || out_ready;
        if (rst) begin
            xfer_a_s = 1'b0;
            xfer_b_s = 1'b0;
        end else begin
            xfer_a_s = accept_s && a_valid && (sel_s == 1'b0);
            xfer_b_s = accept_s && b_valid && (sel_s == 1'b1);
        end
        xfer_s = xfer_a_s || xfer_b_s;
    end

    // State register for the output-stage FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: a transfer always lands a beat; a drain with no refill empties.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (xfer_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (!out_ready) begin
                    state_nxt_s = ST_FULL;
                end else if (xfer_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // Output decode: out_valid comes straight from the state flop.
    always_comb begin
        out_valid = (state_r == ST_FULL);
        a_ready   = xfer_a_s;
        b_ready   = xfer_b_s;
        sel       = sel_s;
        out_data  = out_data_r;
        out_src   = out_src_r;
    end

    // Payload, source tag and round-robin pointer capture on each transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r   <= {W{1'b0}};
            out_src_r    <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (xfer_s) begin
            out_data_r   <= sel_s ? b_data : a_data;
            out_src_r    <= sel_s;
            last_grant_r <= sel_s;
        end else begin
            out_data_r   <= out_data_r;
            out_src_r    <= out_src_r;
            last_grant_r <= last_grant_r;
        end
    end

`ifdef MUX_SEL_ARB_STATS_EN
    logic [CNT_W-1:0] a_cnt_r;
    logic [CNT_W-1:0] b_cnt_r;

    // Grant counters: clear wins over increment; increments wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt_r <= {CNT_W{1'b0}};
            b_cnt_r <= {CNT_W{1'b0}};
        end else if (stats_clr) begin
            a_cnt_r <= {CNT_W{1'b0}};
            b_cnt_r <= {CNT_W{1'b0}};
        end else begin
            a_cnt_r <= a_cnt_r + {{(CNT_W-1){1'b0}}, xfer_a_s};
            b_cnt_r <= b_cnt_r + {{(CNT_W-1){1'b0}}, xfer_b_s};
        end
    end

    // Counter outputs are taken directly from their registers.
    always_comb begin
        a_grant_cnt = a_cnt_r;
        b_grant_cnt = b_cnt_r;
    end
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed self-checking bench for mux_sel_arbiter.
module tb_mux_sel_arbiter;

    localparam int W     = 8;
`ifdef MUX_SEL_ARB_STATS_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         a_valid, b_valid, out_ready;
    logic [W-1:0] a_data, b_data;
    logic         a_ready, b_ready, sel, out_valid, out_src;
    logic [W-1:0] out_data;
`ifdef MUX_SEL_ARB_STATS_EN
    logic             stats_clr;
    logic [CNT_W-1:0] a_grant_cnt, b_grant_cnt;
`endif

    int errors = 0;
    int checks = 0;

    mux_sel_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .sel        (sel),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
`ifdef MUX_SEL_ARB_STATS_EN
        .stats_clr  (stats_clr),
        .a_grant_cnt(a_grant_cnt),
        .b_grant_cnt(b_grant_cnt),
`endif
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_data [4];
        logic       exp_sel  [4];
        exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h11; exp_data[3] = 8'h22;
        exp_sel[0]  = 1'b0;  exp_sel[1]  = 1'b1;  exp_sel[2]  = 1'b0;  exp_sel[3]  = 1'b1;

        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b0; out_ready = 1'b1;
        a_data = 8'h00; b_data = 8'h00;
`ifdef MUX_SEL_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        tick(); tick();
        // Reset state
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {24'd0, out_data},  32'd0);
        check("rst_out_src",   {31'd0, out_src},   32'd0);
        check("rst_a_ready",   {31'd0, a_ready},   32'd0);
        a_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("idle_sel_lastgrant", {31'd0, sel}, 32'd1);

        // Contention round-robin, A first after reset
        a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_sel", {31'd0, sel}, {31'd0, exp_sel[i]});
            check("rr_ready_onehot", {30'd0, a_ready, b_ready}, exp_sel[i] ? 32'd1 : 32'd2);
            tick();
            check("rr_out_valid", {31'd0, out_valid}, 32'd1);
            check("rr_out_data",  {24'd0, out_data},  {24'd0, exp_data[i]});
            check("rr_out_src",   {31'd0, out_src},   {31'd0, exp_sel[i]});
        end

        // Single requester A
        b_valid = 1'b0; a_data = 8'h3C;
        #1;
        check("single_a_ready", {31'd0, a_ready}, 32'd1);
        check("single_b_ready", {31'd0, b_ready}, 32'd0);
        tick();
        check("single_out_valid", {31'd0, out_valid}, 32'd1);
        check("single_out_data",  {24'd0, out_data},  32'h3C);
        check("single_out_src",   {31'd0, out_src},   32'd0);

        // Drain: no valid, downstream ready
        a_valid = 1'b0;
        #1;
        check("drain_sel_hold", {31'd0, sel},     32'd0);
        check("drain_a_ready",  {31'd0, a_ready}, 32'd0);
        tick();
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
        check("drain_out_data",  {24'd0, out_data},  32'h3C);
        check("drain_sel_hold2", {31'd0, sel},       32'd0);

        // Backpressure holding AA
        a_valid = 1'b1; a_data = 8'hAA;
        tick();
        check("bp_load", {24'd0, out_data}, 32'hAA);
        out_ready = 1'b0; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_readies", {30'd0, a_ready, b_ready}, 32'd0);
            tick();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_data",  {24'd0, out_data},  32'hAA);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_b_ready", {31'd0, b_ready}, 32'd1);
        tick();
        check("bp_release_data", {24'd0, out_data}, 32'h22);
        check("bp_release_src",  {31'd0, out_src},  32'd1);

        // Asynchronous reset mid-beat
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_data",  {24'd0, out_data},  32'd0);
        check("arst_readies",   {30'd0, a_ready, b_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_sel", {31'd0, sel}, 32'd0);
        tick();
        check("post_rst_data", {24'd0, out_data}, 32'h11);

        // Single requester B
        a_valid = 1'b0; b_data = 8'h5A;
        #1;
        check("single_b_sel",   {31'd0, sel},     32'd1);
        check("single_b_ready", {31'd0, b_ready}, 32'd1);
        tick();
        check("single_b_data",  {24'd0, out_data}, 32'h5A);
        b_valid = 1'b0;

`ifdef MUX_SEL_ARB_STATS_EN
        // Grant counters: 17 A grants wrap a 4-bit counter to 1; clear beats increment
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("cnt_rst_a", {28'd0, a_grant_cnt}, 32'd0);
        a_valid = 1'b1; a_data = 8'h01;
        for (int i = 0; i < 17; i++) tick();
        check("cnt_wrap_a", {28'd0, a_grant_cnt}, 32'd1);
        check("cnt_b_zero", {28'd0, b_grant_cnt}, 32'd0);
        stats_clr = 1'b1;
        tick();
        check("cnt_clr_a", {28'd0, a_grant_cnt}, 32'd0);
        stats_clr = 1'b0;
        tick();
        check("cnt_after_clr_a", {28'd0, a_grant_cnt}, 32'd1);
        a_valid = 1'b0;
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
